compute_dispatch: RTL

//  Issuing end of the compute-instruction interface. It buffers compute instructions from the

---
 rtl/compute_dispatch_pkg.sv | 21 ++
 rtl/compute_instr_fifo.sv | 61 ++++++
 rtl/compute_dispatch.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/compute_dispatch_pkg.sv
// Shared types and constants for the compute-instruction dispatch path.
package compute_dispatch_pkg;

    localparam int NUM_REGS                = 8;
    localparam int BUF_AW                  = $clog2(NUM_REGS);
    localparam int COMPUTE_TIMEOUT_DEFAULT = 256;

    typedef struct packed {
        logic [3:0]        opcode;
        logic [BUF_AW-1:0] buf_addr;
        logic [15:0]       mem_addr;
    } compute_instr_t;

    typedef enum logic [1:0] {
        CD_IDLE,
        CD_ISSUE,
        CD_WAIT,
        CD_ERROR
    } cdisp_state_t;

endpackage

// File: rtl/compute_instr_fifo.sv
// Small synchronous FIFO of compute instructions; head entry is visible without a read cycle.
module compute_instr_fifo
    import compute_dispatch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  compute_instr_t         wr_data,
    input  logic                   pop,
    output compute_instr_t         rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    compute_instr_t mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic           do_push;
    logic           do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/compute_dispatch.sv
// Buffers decoded compute instructions and issues them one at a time, waiting for completion.
module compute_dispatch
    import compute_dispatch_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = COMPUTE_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_opcode,
    input  logic [BUF_AW-1:0] instr_buf_addr,
    input  logic [15:0]       instr_mem_addr,
    output logic              instruction_ready_compute,
    output logic [3:0]        opcode_function,
    output logic [BUF_AW-1:0] buffer_address,
    output logic [15:0]       memory_address,
    input  logic              compute_done,
    input  logic              clr_err,
    output logic              busy,
    output logic              timeout_err,
    output logic              spurious_done,
    output logic [15:0]       issued_count
);

    localparam int              TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    cdisp_state_t   state_reg, state_next;
    logic [TW-1:0]  timer_reg, timer_next;
    compute_instr_t payload_reg;
    compute_instr_t fifo_head;
    compute_instr_t fifo_wr;
    logic           timeout_reg;
    logic           spurious_reg;
    logic [15:0]    count_reg;
    logic           fifo_full;
    logic           fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic           push;
    logic           pop;
    logic           done_ok;
    logic           timeout_set;

    assign fifo_wr = '{opcode: instr_opcode, buf_addr: instr_buf_addr, mem_addr: instr_mem_addr};
    assign push    = instr_valid && !fifo_full;

    compute_instr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (fifo_wr),
        .pop     (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg;
        pop         = 1'b0;
        done_ok     = 1'b0;
        timeout_set = 1'b0;
        case (state_reg)
            CD_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = CD_ISSUE;
                end
            end
            CD_ISSUE: begin
                state_next = CD_WAIT;
                timer_next = '0;
            end
            CD_WAIT: begin
                // A completion arriving on the expiry cycle still counts as on time.
                if (compute_done) begin
                    done_ok    = 1'b1;
                    state_next = CD_IDLE;
                end else if (timer_reg == TIMER_LAST) begin
                    timeout_set = 1'b1;
                    state_next  = CD_ERROR;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            CD_ERROR: begin
                if (clr_err) begin
                    state_next = CD_IDLE;
                end
            end
            default: state_next = CD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= CD_IDLE;
            timer_reg    <= '0;
            payload_reg  <= '0;
            timeout_reg  <= 1'b0;
            spurious_reg <= 1'b0;
            count_reg    <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            if (pop) begin
                payload_reg <= fifo_head;
            end
            if (done_ok) begin
                count_reg <= count_reg + 1'b1;
            end
            if (timeout_set) begin
                timeout_reg <= 1'b1;
            end else if (clr_err) begin
                timeout_reg <= 1'b0;
            end
            // Completion outside WAIT (including the issue cycle itself) is flagged; set beats clear.
            if (compute_done && state_reg != CD_WAIT) begin
                spurious_reg <= 1'b1;
            end else if (clr_err) begin
                spurious_reg <= 1'b0;
            end
        end
    end

    assign instr_ready               = !fifo_full;
    assign instruction_ready_compute = (state_reg == CD_ISSUE);
    assign opcode_function           = payload_reg.opcode;
    assign buffer_address            = payload_reg.buf_addr;
    assign memory_address            = payload_reg.mem_addr;
    assign busy                      = (state_reg != CD_IDLE) || (fifo_count != '0);
    assign timeout_err               = timeout_reg;
    assign spurious_done             = spurious_reg;
    assign issued_count              = count_reg;

endmodule
